// File: rtl/multicycle_control.sv
// Multicycle control FSM: latches each instruction and steps it through IF/DEC/EXE/MEM/WB,
// driving every datapath select/enable; illegal opcodes or a stalled memory park it in HALT.
module multicycle_control #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] Instr,
    input  logic        ALU_zero,
    input  logic        Mem_ack,
    output logic        Instr_LdEn,
    output logic        PC_LdEn,
    output logic        PC_sel,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic        RF_B_sel,
    output logic        sb,
    output logic        lb,
    output logic        ALU_Bin_sel,
    output logic [3:0]  ALU_func,
    output logic        Mem_RdEn,
    output logic        Mem_WrEn,
    output logic        Halted
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_DEC  = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'b100000;
    localparam logic [5:0] OP_LI   = 6'b111000;
    localparam logic [5:0] OP_LUI  = 6'b111001;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_B    = 6'b111111;
    localparam logic [5:0] OP_BEQ  = 6'b000000;
    localparam logic [5:0] OP_BNE  = 6'b000001;
    localparam logic [5:0] OP_LB   = 6'b000011;
    localparam logic [5:0] OP_SB   = 6'b000111;
    localparam logic [5:0] OP_LW   = 6'b001111;
    localparam logic [5:0] OP_SW   = 6'b011111;

    // Counter value seen during the last permitted MEM cycle without an ack.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t      state;
    logic [5:0]  op_q;
    logic [3:0]  func_q;
    logic [7:0]  wait_cnt;

    // Only the opcode and the low function bits steer control.
    logic unused_instr_bits;
    assign unused_instr_bits = ^Instr[25:4];

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_R, OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI, OP_B,
            OP_BEQ, OP_BNE, OP_LB, OP_SB, OP_LW, OP_SW: is_legal = 1'b1;
            default:                                     is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        is_load = (op == OP_LB) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        is_store = (op == OP_SB) || (op == OP_SW);
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        is_branch = (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic [3:0] imm_alu_func(input logic [5:0] op);
        case (op)
            OP_ANDI: imm_alu_func = 4'b0010;
            OP_ORI:  imm_alu_func = 4'b0011;
            default: imm_alu_func = 4'b0000;
        endcase
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_IF;
            op_q     <= '0;
            func_q   <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IF: begin
                    op_q   <= Instr[31:26];
                    func_q <= Instr[3:0];
                    state  <= S_DEC;
                end
                S_DEC: begin
                    if (!is_legal(op_q))
                        state <= S_HALT;
                    else if (op_q == OP_B)
                        state <= S_IF;
                    else
                        state <= S_EXE;
                end
                S_EXE: begin
                    if (is_branch(op_q))
                        state <= S_IF;
                    else if (is_load(op_q) || is_store(op_q))
                        state <= S_MEM;
                    else
                        state <= S_WB;
                end
                S_MEM: begin
                    if (Mem_ack) begin
                        wait_cnt <= '0;
                        state    <= is_load(op_q) ? S_WB : S_IF;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        state    <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WB:    state <= S_IF;
                S_HALT:  state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

    // Outputs decode state and latched opcode; they are forced low while reset is held.
    always_comb begin
        Instr_LdEn    = 1'b0;
        PC_LdEn       = 1'b0;
        PC_sel        = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        sb            = 1'b0;
        lb            = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = 4'b0000;
        Mem_RdEn      = 1'b0;
        Mem_WrEn      = 1'b0;
        Halted        = 1'b0;
        if (Reset_n) begin
            case (state)
                S_IF: Instr_LdEn = 1'b1;
                S_DEC: begin
                    RF_B_sel = (op_q != OP_R);
                    if (op_q == OP_B) begin
                        PC_LdEn = 1'b1;
                        PC_sel  = 1'b1;
                    end
                end
                S_EXE: begin
                    if (op_q == OP_R) begin
                        ALU_func = func_q;
                    end else if (is_branch(op_q)) begin
                        ALU_func = 4'b0001;
                        PC_LdEn  = 1'b1;
                        PC_sel   = (op_q == OP_BEQ) ? ALU_zero : !ALU_zero;
                    end else begin
                        ALU_Bin_sel = 1'b1;
                        ALU_func    = imm_alu_func(op_q);
                    end
                end
                S_MEM: begin
                    Mem_RdEn = is_load(op_q);
                    Mem_WrEn = is_store(op_q);
                    sb       = (op_q == OP_SB);
                    // A store retires in the cycle its write is acknowledged.
                    if (Mem_ack && is_store(op_q))
                        PC_LdEn = 1'b1;
                end
                S_WB: begin
                    RF_WrEn       = 1'b1;
                    PC_LdEn       = 1'b1;
                    RF_WrData_sel = is_load(op_q);
                    lb            = (op_q == OP_LB);
                end
                S_HALT:  Halted = 1'b1;
                default: Halted = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each test queues per-cycle stimulus with the
// expected control vector, and the drain task replays and compares it cycle by cycle.
module tb_multicycle_control;

    logic        Clk;
    logic        Reset_n;
    logic [31:0] Instr;
    logic        ALU_zero;
    logic        Mem_ack;
    logic        Instr_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel;
    logic        sb, lb, ALU_Bin_sel, Mem_RdEn, Mem_WrEn, Halted;
    logic [3:0]  ALU_func;

    multicycle_control #(.MEM_WAIT_MAX(15)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .ALU_zero(ALU_zero), .Mem_ack(Mem_ack),
        .Instr_LdEn(Instr_LdEn), .PC_LdEn(PC_LdEn), .PC_sel(PC_sel), .RF_WrEn(RF_WrEn),
        .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .sb(sb), .lb(lb),
        .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func), .Mem_RdEn(Mem_RdEn),
        .Mem_WrEn(Mem_WrEn), .Halted(Halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [15:0] outs;
    assign outs = {Instr_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel, sb, lb,
                   ALU_Bin_sel, ALU_func, Mem_RdEn, Mem_WrEn, Halted};

    localparam logic [15:0] ILD  = 16'h8000;
    localparam logic [15:0] PLD  = 16'h4000;
    localparam logic [15:0] PSEL = 16'h2000;
    localparam logic [15:0] RFW  = 16'h1000;
    localparam logic [15:0] WDS  = 16'h0800;
    localparam logic [15:0] BSEL = 16'h0400;
    localparam logic [15:0] SBO  = 16'h0200;
    localparam logic [15:0] LBO  = 16'h0100;
    localparam logic [15:0] BIN  = 16'h0080;
    localparam logic [15:0] MRD  = 16'h0004;
    localparam logic [15:0] MWR  = 16'h0002;
    localparam logic [15:0] HLT  = 16'h0001;
    localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

    function automatic logic [15:0] fn(input logic [3:0] f);
        fn = {9'b0, f, 3'b0};
    endfunction

    typedef struct packed {
        logic [31:0] instr;
        logic        ack;
        logic        zero;
        logic [15:0] exp;
    } step_t;

    step_t sb_q[$];
    int total = 0;
    int bad   = 0;

    task automatic push(input logic [31:0] ins, input logic ack, input logic zero,
                        input logic [15:0] exp);
        step_t s;
        s.instr = ins;
        s.ack   = ack;
        s.zero  = zero;
        s.exp   = exp;
        sb_q.push_back(s);
    endtask

    // Called at posedge+1; leaves the bench at posedge+1 again.
    task automatic drain(input string name);
        step_t s;
        int n = 0;
        while (sb_q.size() != 0) begin
            s = sb_q.pop_front();
            Instr    = s.instr;
            Mem_ack  = s.ack;
            ALU_zero = s.zero;
            @(negedge Clk);
            total++;
            if (outs !== s.exp) begin
                bad++;
                $display("FAIL %s step %0d: outs=%04h expected=%04h", name, n, outs, s.exp);
            end
            n++;
            @(posedge Clk);
            #1;
        end
        Mem_ack  = 1'b0;
        ALU_zero = 1'b0;
    endtask

    task automatic push_li();
        push(32'hE001_0007, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b0, BIN | fn(4'h0));
        push(JUNK, 1'b0, 1'b0, RFW | PLD);
    endtask

    task automatic test_reset();
        Reset_n  = 1'b0;
        Instr    = 32'hE001_0007;
        Mem_ack  = 1'b1;
        ALU_zero = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        total++;
        if (outs !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outputs: outs=%04h expected=0000", outs);
        end
        Mem_ack  = 1'b0;
        ALU_zero = 1'b0;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic test_alu_imm();
        // li with Mem_ack held high throughout: ack must be ignored outside MEM
        push(32'hE001_0007, 1'b1, 1'b0, ILD);
        push(JUNK, 1'b1, 1'b0, BSEL);
        push(JUNK, 1'b1, 1'b0, BIN | fn(4'h0));
        push(JUNK, 1'b1, 1'b0, RFW | PLD);
        drain("li");
        push(32'hE400_1234, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b0, BIN | fn(4'h0));
        push(JUNK, 1'b0, 1'b0, RFW | PLD);
        drain("lui");
        push(32'hC021_0005, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b0, BIN | fn(4'h0));
        push(JUNK, 1'b0, 1'b0, RFW | PLD);
        drain("addi");
        push(32'hC821_00FF, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b0, BIN | fn(4'h2));
        push(JUNK, 1'b0, 1'b0, RFW | PLD);
        drain("andi");
        push(32'hCC21_00F0, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b0, BIN | fn(4'h3));
        push(JUNK, 1'b0, 1'b0, RFW | PLD);
        drain("ori");
    endtask

    task automatic test_rtype();
        logic [31:0] words [3];
        logic [3:0]  funcs [3];
        words = '{32'h8023_1030, 32'h8023_1032, 32'h8023_103F};
        funcs = '{4'h0, 4'h2, 4'hF};
        for (int i = 0; i < 3; i++) begin
            push(words[i], 1'b0, 1'b0, ILD);
            push(JUNK, 1'b0, 1'b0, 16'h0000);
            push(JUNK, 1'b0, 1'b0, fn(funcs[i]));
            push(JUNK, 1'b0, 1'b0, RFW | PLD);
            drain("rtype");
        end
    endtask

    task automatic test_load();
        push(32'h0C24_0005, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b0, BIN | fn(4'h0));
        push(JUNK, 1'b0, 1'b0, MRD);
        push(JUNK, 1'b1, 1'b0, MRD);
        push(JUNK, 1'b0, 1'b0, RFW | PLD | WDS | LBO);
        drain("lb");
        push(32'h3C24_0008, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b0, BIN | fn(4'h0));
        push(JUNK, 1'b1, 1'b0, MRD);
        push(JUNK, 1'b0, 1'b0, RFW | PLD | WDS);
        drain("lw");
    endtask

    task automatic test_store();
        push(32'h1C23_0005, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b0, BIN | fn(4'h0));
        push(JUNK, 1'b1, 1'b0, MWR | SBO | PLD);
        drain("sb");
        push(32'h7C23_0004, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b0, BIN | fn(4'h0));
        push(JUNK, 1'b0, 1'b0, MWR);
        push(JUNK, 1'b0, 1'b0, MWR);
        push(JUNK, 1'b1, 1'b0, MWR | PLD);
        drain("sw");
    endtask

    task automatic test_branch();
        push(32'h0022_000A, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b1, fn(4'h1) | PLD | PSEL);
        drain("beq_taken");
        push(32'h0022_000A, 1'b0, 1'b1, ILD);
        push(JUNK, 1'b0, 1'b1, BSEL);
        push(JUNK, 1'b0, 1'b0, fn(4'h1) | PLD);
        drain("beq_not_taken");
        push(32'h0422_0003, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b0, fn(4'h1) | PLD | PSEL);
        drain("bne_taken");
        push(32'h0422_0003, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b1, fn(4'h1) | PLD);
        drain("bne_not_taken");
        push(32'hFC00_0004, 1'b0, 1'b0, ILD);
        push(32'h0000_0000, 1'b0, 1'b0, BSEL | PLD | PSEL);
        drain("b");
    endtask

    task automatic test_back_to_back();
        push(32'hFC00_0010, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL | PLD | PSEL);
        push(32'hC821_0001, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b0, BIN | fn(4'h2));
        push(JUNK, 1'b0, 1'b0, RFW | PLD);
        push(32'h1C23_0005, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b0, BIN | fn(4'h0));
        push(JUNK, 1'b0, 1'b0, MWR | SBO);
        push(JUNK, 1'b1, 1'b0, MWR | SBO | PLD);
        push(32'h3C24_0008, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b0, BIN | fn(4'h0));
        push(JUNK, 1'b1, 1'b0, MRD);
        push(JUNK, 1'b0, 1'b0, RFW | PLD | WDS);
        drain("back_to_back");
    endtask

    task automatic test_halt_illegal();
        push(32'hA800_0000, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        for (int i = 0; i < 4; i++)
            push(32'hE001_0007, 1'b1, 1'b1, HLT);
        drain("illegal_halt");
        Reset_n = 1'b0;
        @(negedge Clk);
        total++;
        if (outs !== 16'h0000) begin
            bad++;
            $display("FAIL halt_reset: outs=%04h expected=0000", outs);
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        push_li();
        drain("li_after_halt");
    endtask

    task automatic test_mem_timeout();
        push(32'h7C23_0004, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b0, BIN | fn(4'h0));
        for (int i = 0; i < 15; i++)
            push(JUNK, 1'b0, 1'b0, MWR);
        for (int i = 0; i < 3; i++)
            push(JUNK, 1'b1, 1'b0, HLT);
        drain("sw_timeout");
        Reset_n = 1'b0;
        @(negedge Clk);
        total++;
        if (Halted !== 1'b0) begin
            bad++;
            $display("FAIL timeout_reset_halted: Halted=%b expected=0", Halted);
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        push_li();
        drain("li_after_timeout");
    endtask

    task automatic test_reset_mid();
        push(32'h3C24_0008, 1'b0, 1'b0, ILD);
        push(JUNK, 1'b0, 1'b0, BSEL);
        push(JUNK, 1'b0, 1'b0, BIN | fn(4'h0));
        push(JUNK, 1'b0, 1'b0, MRD);
        drain("lw_partial");
        Reset_n = 1'b0;
        Mem_ack = 1'b1;
        @(negedge Clk);
        total++;
        if (outs !== 16'h0000) begin
            bad++;
            $display("FAIL reset_mid_outputs: outs=%04h expected=0000", outs);
        end
        @(posedge Clk);
        #1;
        Mem_ack = 1'b0;
        Reset_n = 1'b1;
        push_li();
        drain("li_after_abort");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_imm();
        test_rtype();
        test_load();
        test_store();
        test_branch();
        test_back_to_back();
        test_halt_illegal();
        test_mem_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
